adc_pattern_gen: RTL and testbench

- AD9643-style ADC output emulator: drives a parallel data bus plus an out-of-range (OR) flag with deterministic test patterns.
- Sits at the transmit end of the ADC capture path, upstream of the input-delay block.
- Used in loopback and simulation to train and verify delay tap settings and capture logic without a physical ADC.
- Each run emits a checkerboard sync preamble, then a selectable pattern, either as a burst or continuously.

---
 rtl/adc_pattern_gen.sv | 174 +++++++++++++++++
 tb/tb_adc_pattern_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_pattern_gen.sv
// AD9643-style ADC emulator: checkerboard sync preamble followed by a selectable test pattern.
// Build with ADC_PAT_PN23_EN defined to make mode 5 emit PN23 instead of midscale.
module adc_pattern_gen #(
    parameter int DATA_WIDTH = 14,
    parameter int SYNC_LEN   = 16,
    parameter int BURST_W    = 16
) (
    input  logic                  clk_adc,
    input  logic                  rst_adc,
    input  logic                  start,
    input  logic                  stop,
    input  logic [2:0]            mode,
    input  logic [DATA_WIDTH-1:0] user_word,
    input  logic [BURST_W-1:0]    burst_len,
    output logic [DATA_WIDTH-1:0] adc_dat_out,
    output logic                  adc_or_out,
    output logic                  dat_valid,
    output logic                  sync_phase,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int SYNC_CW = (SYNC_LEN > 2) ? $clog2(SYNC_LEN) : 1;
    localparam logic [SYNC_CW-1:0] SYNC_LAST = SYNC_CW'(SYNC_LEN - 1);
    localparam logic [SYNC_CW-1:0] SYNC_ONE  = SYNC_CW'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
    localparam logic [DATA_WIDTH-1:0] RAMP_ONE = DATA_WIDTH'(1);

    // Checkerboard words: bit 0 is 0 in CHK_A, so CHK_A reads 1010.. from the MSB down
    localparam logic [2*(DATA_WIDTH/2+1)-1:0] CHK_WIDE = {(DATA_WIDTH/2+1){2'b10}};
    localparam logic [DATA_WIDTH-1:0] CHK_A = CHK_WIDE[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] CHK_B = ~CHK_A;
    localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]            state;
    logic [SYNC_CW-1:0]    sync_cnt;
    logic [BURST_W-1:0]    run_cnt;
    logic [DATA_WIDTH-1:0] ramp;
    logic [8:0]            lfsr9;
    logic [DATA_WIDTH-1:0] sh;
    logic [2:0]            mode_q;
    logic [DATA_WIDTH-1:0] user_q;
    logic [BURST_W-1:0]    burst_q;

    logic                  pn9;
    logic [8:0]            lfsr9_next;
    logic [DATA_WIDTH-1:0] run_word;
    logic                  run_or;
    logic                  burst_done;

`ifdef ADC_PAT_PN23_EN
    logic [22:0] lfsr23;
    logic        pn23;
    logic [22:0] lfsr23_next;
`endif

    // Pattern word for the next RUN emission; PN words are the shift register after one step
    always_comb begin
        pn9        = lfsr9[8] ^ lfsr9[4];
        lfsr9_next = {lfsr9[7:0], pn9};
`ifdef ADC_PAT_PN23_EN
        pn23        = lfsr23[22] ^ lfsr23[17];
        lfsr23_next = {lfsr23[21:0], pn23};
`endif
        run_word = MIDSCALE;
        case (mode_q)
            3'd1:    run_word = ramp;
            3'd2:    run_word = ramp[0] ? CHK_B : CHK_A;
            3'd3:    run_word = {sh[DATA_WIDTH-2:0], pn9};
            3'd4:    run_word = user_q;
`ifdef ADC_PAT_PN23_EN
            3'd5:    run_word = {sh[DATA_WIDTH-2:0], pn23};
`endif
            default: run_word = MIDSCALE;
        endcase
        run_or     = (run_word == '0) || (run_word == '1);
        burst_done = (burst_q != '0) && (run_cnt == burst_q - BURST_ONE);
    end

    // Outputs are registered alongside the state so that a word and its flags always line up
    always_ff @(posedge clk_adc or posedge rst_adc) begin
        if (rst_adc) begin
            state       <= ST_IDLE;
            sync_cnt    <= '0;
            run_cnt     <= '0;
            ramp        <= '0;
            lfsr9       <= '1;
            sh          <= '1;
            mode_q      <= '0;
            user_q      <= '0;
            burst_q     <= '0;
            adc_dat_out <= '0;
            adc_or_out  <= 1'b0;
            dat_valid   <= 1'b0;
            sync_phase  <= 1'b0;
            busy        <= 1'b0;
`ifdef ADC_PAT_PN23_EN
            lfsr23      <= '1;
`endif
        end else begin
            case (state)
                ST_SYNC, ST_RUN: begin
                    if (stop) begin
                        state       <= ST_IDLE;
                        adc_dat_out <= '0;
                        adc_or_out  <= 1'b0;
                        dat_valid   <= 1'b0;
                        sync_phase  <= 1'b0;
                        busy        <= 1'b0;
                    end else if (state == ST_SYNC) begin
                        adc_dat_out <= sync_cnt[0] ? CHK_B : CHK_A;
                        adc_or_out  <= 1'b0;
                        dat_valid   <= 1'b1;
                        sync_phase  <= 1'b1;
                        busy        <= 1'b1;
                        if (sync_cnt == SYNC_LAST) begin
                            sync_cnt <= '0;
                            state    <= ST_RUN;
                        end else begin
                            sync_cnt <= sync_cnt + SYNC_ONE;
                        end
                    end else begin
                        adc_dat_out <= run_word;
                        adc_or_out  <= run_or;
                        dat_valid   <= 1'b1;
                        sync_phase  <= 1'b0;
                        busy        <= 1'b1;
                        ramp        <= ramp + RAMP_ONE;
                        run_cnt     <= run_cnt + BURST_ONE;
                        if (mode_q == 3'd3) begin
                            lfsr9 <= lfsr9_next;
                            sh    <= run_word;
                        end
`ifdef ADC_PAT_PN23_EN
                        if (mode_q == 3'd5) begin
                            lfsr23 <= lfsr23_next;
                            sh     <= run_word;
                        end
`endif
                        if (burst_done) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    adc_dat_out <= '0;
                    adc_or_out  <= 1'b0;
                    dat_valid   <= 1'b0;
                    sync_phase  <= 1'b0;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                    if (start) begin
                        state    <= ST_SYNC;
                        mode_q   <= mode;
                        user_q   <= user_word;
                        burst_q  <= burst_len;
                        sync_cnt <= '0;
                        run_cnt  <= '0;
                        ramp     <= '0;
                        lfsr9    <= '1;
                        sh       <= '1;
`ifdef ADC_PAT_PN23_EN
                        lfsr23   <= '1;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Scoreboard bench for adc_pattern_gen: expected words are queued at stimulus time and
// popped by an independent monitor whenever dat_valid is high.
module tb_adc_pattern_gen;

    localparam int DW = 14;
    localparam int SL = 16;
    localparam int BW = 16;

    logic          clk_adc = 1'b0;
    logic          rst_adc = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [2:0]    mode = '0;
    logic [DW-1:0] user_word = '0;
    logic [BW-1:0] burst_len = '0;
    logic [DW-1:0] adc_dat_out;
    logic          adc_or_out;
    logic          dat_valid;
    logic          sync_phase;
    logic          busy;

    int checks = 0;
    int failures = 0;

    // Entry layout: [15] sync_phase, [14] OR flag, [13:0] data word
    logic [15:0] exp_q[$];

    adc_pattern_gen #(.DATA_WIDTH(DW), .SYNC_LEN(SL), .BURST_W(BW)) dut (
        .clk_adc(clk_adc),
        .rst_adc(rst_adc),
        .start(start),
        .stop(stop),
        .mode(mode),
        .user_word(user_word),
        .burst_len(burst_len),
        .adc_dat_out(adc_dat_out),
        .adc_or_out(adc_or_out),
        .dat_valid(dat_valid),
        .sync_phase(sync_phase),
        .busy(busy)
    );

    always #5 clk_adc = ~clk_adc;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_idle(input string name);
        checkOutput(name, {15'd0, busy, dat_valid, sync_phase, adc_or_out, adc_dat_out}, 32'd0);
    endtask

    // Monitor: every valid word must match the head of the scoreboard, with busy high
    always @(negedge clk_adc) begin
        if (!rst_adc && dat_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_word actual=%0h required=none", adc_dat_out);
            end else begin
                checkOutput("scoreboard", {14'd0, busy, sync_phase, adc_or_out, adc_dat_out},
                            {15'd0, 1'b1, exp_q.pop_front()});
            end
        end
    end

    task automatic push_sync(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({1'b1, 1'b0, ((i % 2) == 1) ? 14'h1555 : 14'h2AAA});
    endtask

    task automatic push_run(input logic [2:0] m, input logic [DW-1:0] uw, input int n);
        logic [DW-1:0] w;
        logic [8:0]    l9;
        logic [22:0]   l23;
        logic [DW-1:0] sh;
        logic          pn;
        logic          orf;
        l9  = 9'h1FF;
        l23 = 23'h7FFFFF;
        sh  = 14'h3FFF;
        for (int i = 0; i < n; i++) begin
            case (m)
                3'd0: w = 14'h2000;
                3'd1: w = i[13:0];
                3'd2: w = ((i % 2) == 0) ? 14'h2AAA : 14'h1555;
                3'd3: begin
                    pn = l9[8] ^ l9[4];
                    l9 = {l9[7:0], pn};
                    sh = {sh[12:0], pn};
                    w  = sh;
                end
                3'd4: w = uw;
`ifdef ADC_PAT_PN23_EN
                3'd5: begin
                    pn  = l23[22] ^ l23[17];
                    l23 = {l23[21:0], pn};
                    sh  = {sh[12:0], pn};
                    w   = sh;
                end
`endif
                default: w = 14'h2000;
            endcase
            orf = (w == 14'h0000) || (w == 14'h3FFF);
            exp_q.push_back({1'b0, orf, w});
        end
    endtask

    task automatic applyStimulus(input logic [2:0] m, input logic [DW-1:0] uw, input logic [BW-1:0] bl);
        @(negedge clk_adc);
        mode      = m;
        user_word = uw;
        burst_len = bl;
        start     = 1'b1;
        @(negedge clk_adc);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_adc);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout actual=%0d_left required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_burst(input string name, input logic [2:0] m, input logic [DW-1:0] uw, input int n);
        push_sync(SL);
        push_run(m, uw, n);
        applyStimulus(m, uw, n[BW-1:0]);
        wait_drain(name, n + SL + 20);
        @(negedge clk_adc);
        check_idle({name, "_end"});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk_adc);
        check_idle("reset_state");
        rst_adc = 1'b0;
        @(negedge clk_adc);
        check_idle("idle_after_reset");

        run_burst("midscale", 3'd0, '0, 4);
        run_burst("ramp_wrap", 3'd1, '0, 16386);
        run_burst("checker", 3'd2, '0, 6);
        run_burst("pn9", 3'd3, '0, 20);
        run_burst("mode5", 3'd5, '0, 8);
        run_burst("mode6", 3'd6, '0, 3);
        run_burst("user", 3'd4, 14'h3FFF, 2);

        // Stop with a simultaneous start during the third RUN word of a continuous run
        push_sync(SL);
        push_run(3'd4, 14'h1234, 3);
        applyStimulus(3'd4, 14'h1234, '0);
        wait_drain("stop_run", SL + 30);
        stop  = 1'b1;
        start = 1'b1;
        @(negedge clk_adc);
        stop  = 1'b0;
        start = 1'b0;
        check_idle("stop_idle");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_adc);
            check_idle("no_restart");
        end

        // Asynchronous reset while the fifth sync word is on the bus
        push_sync(5);
        applyStimulus(3'd0, '0, 16'd4);
        wait_drain("pre_reset", 20);
        rst_adc = 1'b1;
        #1;
        check_idle("async_reset");
        exp_q.delete();
        @(negedge clk_adc);
        #2;
        rst_adc = 1'b0;
        @(negedge clk_adc);
        check_idle("post_reset_idle");
        run_burst("restart", 3'd0, '0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
